instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Instruction fetch/sequencing stage directly upstream of the 8-bit processor core.
- Holds a small loadable program memory of 9-bit instruction words (opcode[8:6], Rx[5:3], Ry[2:0]) and a program counter.
- Drives the core's 9-bit func bus one instruction per cycle, either free-running or single-stepped.
- Drives a harmless NOP word whenever it is not issuing.

Parameters:
- ADDR_W, 4, program-memory address width; depth = 2**ADDR_W words.
- NOP_FUNC, 9'h000, word driven on func when no instruction is issued; the team's designated no-effect encoding.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- load_en  in  1  write load_data into memory at load_addr this cycle
- load_addr  in  ADDR_W  program-memory write address
- load_data  in  9  instruction word to write
- last_addr  in  ADDR_W  address of final instruction; sampled on accepted start
- start  in  1  begin program from address 0
- step_mode  in  1  sampled with start: 0 = free-run, 1 = single-step
- step  in  1  in step mode, issue one instruction per cycle high
- halt_req  in  1  abort current program
- func  out  9  instruction word to core (registered)
- func_valid  out  1  func holds a real fetched instruction this cycle
- pc  out  ADDR_W  address of the next instruction to issue
- busy  out  1  state is RUN or STEP
- done  out  1  single-cycle pulse after final instruction is issued

Behaviour:
- Reset values: func=NOP_FUNC, func_valid=0, pc=0, busy=0, done=0, state=IDLE, latched last=0. Memory contents are not cleared by reset.
- States: IDLE, RUN, STEP, DONE. Encoding is 2-bit.
- IDLE/DONE, start=1, halt_req=0:
  - pc<=0, last<=last_addr.
  - Next state is RUN if step_mode=0, otherwise STEP.
- RUN, every cycle:
  - func<=mem[pc], func_valid<=1.
  - If pc==last: next state DONE, done<=1, pc holds. Otherwise pc<=pc+1.
  - First valid func appears on the second rising edge after start is sampled.
- STEP:
  - step=1: same issue as one RUN cycle.
  - step=0: func<=NOP_FUNC, func_valid<=0, pc holds.
- DONE:
  - func<=NOP_FUNC, func_valid<=0, done<=0 after its pulse.
  - Remains in DONE until start.
- Outside an issuing cycle, func=NOP_FUNC and func_valid=0 are always registered.
- halt_req=1 in any state:
  - next state IDLE, func<=NOP_FUNC, func_valid<=0, pc<=0, no done pulse.
  - halt_req has priority over start and step in the same cycle.
- start while busy: ignored.
- load_en:
  - Accepted only when busy=0; ignored while busy, and memory is unchanged.
  - A write and a start in the same cycle are both honoured; the write completes before the first fetch.
- last_addr = 0 gives a one-instruction program.
- last_addr = 2**ADDR_W-1 runs the full memory. pc never wraps, except under the optional feature.
- Reset asserted mid-program: returns to reset values on that edge; no partial issue.
- Memory is written synchronously and read asynchronously (register array).

Optional Feature:
- Macro SEQ_LOOP_EN.
- Defined: in RUN, when pc==last, pc<=0 and state stays RUN. done pulses every pass. The program repeats until halt_req.
- In STEP, the same wrap applies per step.
- Not defined: behaviour exactly as above; the sequence terminates in DONE.

Decomposition:
- Shared package `proc_pkg`:
  - FUNC_W=9, OPC_W=3, REG_SEL_W=3.
  - Field-slice constants for opcode/Rx/Ry.
  - Default NOP encoding.
  - seq_state_t enum {IDLE, RUN, STEP, DONE}.
- Sub-module `seq_imem`: parameterised 2**ADDR_W x 9 register array with a write port (we, waddr, wdata) and an async read port (raddr, rdata).
- The FSM and PC stay in instr_sequencer.

Test Plan:
- Load 0:9'h0C1, 1:9'h14A, 2:9'h1D3; last_addr=2, start, step_mode=0 -> func_valid high 3 cycles; func = 0C1, 14A, 1D3; done pulses once; then func=000, busy=0.
- Same program, step_mode=1, step high on cycles 3 and 7 only -> exactly two valid words (0C1, 14A); pc=2; busy stays 1.
- Free-run with last_addr=15 over 16 loaded words, halt_req asserted on the 5th valid cycle -> next cycle func=000, func_valid=0, pc=0, no done.
- load_en during RUN to addr 1 with 9'h1FF, then rerun -> original 9'h14A is issued at addr 1.
- start and halt_req together in IDLE -> stays IDLE; reset asserted mid-run -> func=000, pc=0, busy=0 next edge, and memory is intact on rerun.
- SEQ_LOOP_EN defined, last_addr=1 -> func sequence 0C1, 14A, 0C1, 14A…; done pulses every 2 cycles until halt_req.

Source files
------------

// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Definitions shared by the 8-bit core and its instruction sequencer.
//   - Instruction word geometry: opcode[8:6], Rx[5:3], Ry[2:0]
//   - Default no-effect instruction encoding
//   - Sequencer FSM state type
// No ports (package).
// ----------------------------------------------------------------------------
package proc_pkg;

    localparam int unsigned FUNC_W    = 9;
    localparam int unsigned OPC_W     = 3;
    localparam int unsigned REG_SEL_W = 3;

    // Field positions inside a func word.
    localparam int unsigned OPC_MSB = 8;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned RX_MSB  = 5;
    localparam int unsigned RX_LSB  = 3;
    localparam int unsigned RY_MSB  = 2;
    localparam int unsigned RY_LSB  = 0;

    // Word the core treats as "do nothing".
    localparam logic [FUNC_W-1:0] FUNC_NOP = 9'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    function automatic logic [OPC_W-1:0] func_opcode(input logic [FUNC_W-1:0] f);
        return f[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [REG_SEL_W-1:0] func_rx(input logic [FUNC_W-1:0] f);
        return f[RX_MSB:RX_LSB];
    endfunction

    function automatic logic [REG_SEL_W-1:0] func_ry(input logic [FUNC_W-1:0] f);
        return f[RY_MSB:RY_LSB];
    endfunction

endpackage

// File: rtl/seq_imem.sv
// ----------------------------------------------------------------------------
// seq_imem
// Program memory for the instruction sequencer: 2**ADDR_W words of FUNC_W bits,
// held in a plain register array (no reset, contents survive reset).
// Ports:
//   clock  in   write clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (asynchronous read)
//   rdata  out  word at raddr, combinational
// ----------------------------------------------------------------------------
module seq_imem
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                clock,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [FUNC_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [FUNC_W-1:0]   rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [FUNC_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
// Fetch/sequencing stage in front of the 8-bit core. Holds a loadable program
// memory and a program counter, and issues one instruction word per cycle on
// func, either free-running or single-stepped. When nothing is issued, func
// carries NOP_FUNC and func_valid is low.
//
// Build option:
//   SEQ_LOOP_EN  when defined, reaching the last address wraps pc to 0 and the
//                program repeats (done pulses every pass) until halt_req.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   load_en    in   write load_data at load_addr (ignored while busy)
//   load_addr  in   program-memory write address
//   load_data  in   instruction word to write
//   last_addr  in   address of final instruction, latched on accepted start
//   start      in   begin program at address 0 (ignored while busy)
//   step_mode  in   sampled with start: 0 free-run, 1 single-step
//   step       in   single-step: issue one instruction for each cycle high
//   halt_req   in   abort program, back to IDLE (beats start and step)
//   func       out  registered instruction word to the core
//   func_valid out  func holds a fetched instruction this cycle
//   pc         out  address of the next instruction to issue
//   busy       out  state is RUN or STEP
//   done       out  one-cycle pulse with the final instruction's issue
// ----------------------------------------------------------------------------
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 4,
    parameter logic [FUNC_W-1:0] NOP_FUNC = FUNC_NOP
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [FUNC_W-1:0]   load_data,
    input  logic [ADDR_W-1:0]   last_addr,
    input  logic                start,
    input  logic                step_mode,
    input  logic                step,
    input  logic                halt_req,
    output logic [FUNC_W-1:0]   func,
    output logic                func_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                done
);

`ifdef SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] w_last_next;
    logic [FUNC_W-1:0] r_func;
    logic [FUNC_W-1:0] w_func_next;
    logic              r_func_valid;
    logic              w_func_valid_next;
    logic              r_done;
    logic              w_done_next;

    logic [FUNC_W-1:0] w_mem_rdata;
    logic              w_busy;
    logic              w_start_ok;
    logic              w_issue;
    logic              w_at_last;
    logic              w_load_we;

    assign w_busy     = (r_state == RUN) || (r_state == STEP);
    // Only IDLE/DONE accept start; halt_req always wins.
    assign w_start_ok = start && !halt_req && !w_busy;
    assign w_issue    = !halt_req && ((r_state == RUN) || ((r_state == STEP) && step));
    assign w_at_last  = (r_pc == r_last);
    // Writing while a program runs could corrupt it mid-flight, so block it.
    assign w_load_we  = load_en && !w_busy;

    seq_imem #(
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clock (clock),
        .we    (w_load_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (r_pc),
        .rdata (w_mem_rdata)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        if (halt_req) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_state_next = step_mode ? STEP : RUN;
                    end
                end
                RUN: begin
                    if (w_at_last && !LOOP_EN) begin
                        w_state_next = DONE;
                    end
                end
                STEP: begin
                    if (step && w_at_last && !LOOP_EN) begin
                        w_state_next = DONE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------ registered outputs/pc
    always_comb begin
        w_func_next       = NOP_FUNC;
        w_func_valid_next = 1'b0;
        w_done_next       = 1'b0;
        w_pc_next         = r_pc;
        w_last_next       = r_last;
        if (halt_req) begin
            w_pc_next = '0;
        end else if (w_start_ok) begin
            w_pc_next   = '0;
            w_last_next = last_addr;
        end else if (w_issue) begin
            w_func_next       = w_mem_rdata;
            w_func_valid_next = 1'b1;
            if (w_at_last) begin
                w_done_next = 1'b1;
                // Without looping, pc parks on the last address.
                if (LOOP_EN) begin
                    w_pc_next = '0;
                end
            end else begin
                w_pc_next = r_pc + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc         <= '0;
            r_last       <= '0;
            r_func       <= NOP_FUNC;
            r_func_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_last       <= w_last_next;
            r_func       <= w_func_next;
            r_func_valid <= w_func_valid_next;
            r_done       <= w_done_next;
        end
    end

    assign func       = r_func;
    assign func_valid = r_func_valid;
    assign pc         = r_pc;
    assign busy       = w_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam int unsigned AW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [8:0]    load_data = '0;
    logic [AW-1:0] last_addr = '0;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          halt_req = 1'b0;
    logic [8:0]    func;
    logic          func_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] tb_mem[16];

    instr_sequencer #(
        .ADDR_W   (AW),
        .NOP_FUNC (9'h000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .last_addr  (last_addr),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .halt_req   (halt_req),
        .func       (func),
        .func_valid (func_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge and scored.
    task automatic cycle();
        logic [15:0] e;
        @(posedge clock);
        #1;
        if (func_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() != 0) e = {7'b0, exp_q.pop_front()};
            else e = 16'hFFFF;
            check("func_issue", 16'(func), e);
        end else begin
            check("func_nop", 16'(func), 16'h000);
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic clr();
        valid_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic push(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(tb_mem[i]);
    endtask

    task automatic load(input int a, input logic [8:0] d);
        load_en = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        cycle();
        load_en = 1'b0;
    endtask

    task automatic do_start(input int last, input logic mode);
        last_addr = AW'(last);
        step_mode = mode;
        start = 1'b1;
        clr();
        cycle();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        cycle();
        cycle();
        check("rst_func", 16'(func), 16'h000);
        check("rst_valid", 16'(func_valid), 16'd0);
        check("rst_pc", 16'(pc), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) tb_mem[i] = 9'((i * 73 + 5) ^ 'h0A5);
        tb_mem[0] = 9'h0C1;
        tb_mem[1] = 9'h14A;
        tb_mem[2] = 9'h1D3;
        for (int i = 0; i < 16; i++) load(i, tb_mem[i]);

        // Free-run, three words
        push(0, 2);
        do_start(2, 1'b0);
        repeat (5) cycle();
        check("run3_valid", 16'(valid_cnt), 16'd3);
        check("run3_done", 16'(done_cnt), 16'd1);
        check("run3_busy", 16'(busy), 16'd0);
        check("run3_pc", 16'(pc), 16'd2);
        check("run3_q", 16'(exp_q.size()), 16'd0);

        // Single-step, two steps
        push(0, 1);
        do_start(2, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step = (i == 3) || (i == 7);
            cycle();
        end
        step = 1'b0;
        check("step_valid", 16'(valid_cnt), 16'd2);
        check("step_pc", 16'(pc), 16'd2);
        check("step_busy", 16'(busy), 16'd1);
        check("step_done", 16'(done_cnt), 16'd0);
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        check("step_halt_busy", 16'(busy), 16'd0);
        check("step_halt_pc", 16'(pc), 16'd0);

        // Full-memory run, halted on 5th issued word
        push(0, 4);
        do_start(15, 1'b0);
        for (int k = 0; k < 20 && valid_cnt < 5; k++) cycle();
        check("full_valid5", 16'(valid_cnt), 16'd5);
        check("full_pc5", 16'(pc), 16'd5);
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        check("halt_valid", 16'(func_valid), 16'd0);
        check("halt_pc", 16'(pc), 16'd0);
        check("halt_busy", 16'(busy), 16'd0);
        check("halt_nodone", 16'(done_cnt), 16'd0);
        check("halt_q", 16'(exp_q.size()), 16'd0);

        // One-instruction program
        push(0, 0);
        do_start(0, 1'b0);
        repeat (4) cycle();
        check("one_valid", 16'(valid_cnt), 16'd1);
        check("one_done", 16'(done_cnt), 16'd1);
        check("one_pc", 16'(pc), 16'd0);

        // Load and start while running are ignored; rerun shows original word
        push(0, 2);
        do_start(2, 1'b0);
        load_en = 1'b1;
        load_addr = AW'(1);
        load_data = 9'h1FF;
        start = 1'b1;
        cycle();
        load_en = 1'b0;
        start = 1'b0;
        repeat (4) cycle();
        push(0, 2);
        last_addr = AW'(2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        check("noload_valid", 16'(valid_cnt), 16'd6);
        check("noload_done", 16'(done_cnt), 16'd2);
        check("noload_q", 16'(exp_q.size()), 16'd0);

        // start together with halt_req stays idle
        halt_req = 1'b1;
        do_start(2, 1'b0);
        halt_req = 1'b0;
        check("sh_busy0", 16'(busy), 16'd0);
        cycle();
        check("sh_busy1", 16'(busy), 16'd0);
        check("sh_valid", 16'(valid_cnt), 16'd0);

        // Reset mid-run, then memory intact
        push(0, 2);
        do_start(15, 1'b0);
        for (int k = 0; k < 20 && valid_cnt < 3; k++) cycle();
        check("mid_valid3", 16'(valid_cnt), 16'd3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_func", 16'(func), 16'h000);
        check("mid_rst_valid", 16'(func_valid), 16'd0);
        check("mid_rst_pc", 16'(pc), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        push(0, 2);
        do_start(2, 1'b0);
        repeat (5) cycle();
        check("rerun_valid", 16'(valid_cnt), 16'd3);
        check("rerun_q", 16'(exp_q.size()), 16'd0);

        // Write and start in the same cycle: new word is fetched
        load_en = 1'b1;
        load_addr = AW'(0);
        load_data = 9'h0AA;
        tb_mem[0] = 9'h0AA;
        push(0, 0);
        do_start(0, 1'b0);
        load_en = 1'b0;
        repeat (4) cycle();
        check("ldst_valid", 16'(valid_cnt), 16'd1);
        check("ldst_q", 16'(exp_q.size()), 16'd0);

`ifdef SEQ_LOOP_EN
        push(0, 1);
        push(0, 1);
        push(0, 1);
        do_start(1, 1'b0);
        repeat (6) cycle();
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        check("loop_valid", 16'(valid_cnt), 16'd6);
        check("loop_done", 16'(done_cnt), 16'd3);
        check("loop_pc", 16'(pc), 16'd0);
        check("loop_busy", 16'(busy), 16'd0);
`else
        push(0, 1);
        do_start(1, 1'b0);
        repeat (5) cycle();
        check("two_valid", 16'(valid_cnt), 16'd2);
        check("two_done", 16'(done_cnt), 16'd1);
        check("two_busy", 16'(busy), 16'd0);
`endif
        check("end_q", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
